// File: rtl/cpu_core_param.sv
// Parametrised multi-cycle CPU core: FETCH/DECODE/EXECUTE over an external
// synchronous-read instruction memory, NREG x DATA_W register file, Z/C flags.
module cpu_core_param #(
    parameter int DATA_W  = 4,
    parameter int NREG    = 4,
    parameter int ADDR_W  = 4,
    localparam int RS_W    = $clog2(NREG),
    localparam int INSTR_W = 4 + 2*RS_W + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               halted,
    output logic               flag_z,
    output logic               flag_c,
    output logic [1:0]         state,
    input  logic [RS_W-1:0]    dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    // run is a level qualifier sampled only in FETCH; out_valid is a one-cycle
    // strobe with no back-pressure, issued the cycle after an OUT executes.
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t              st, st_nx;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NREG];
    logic [ADDR_W-1:0]   pc;
    logic                z_q, c_q;
    logic [DATA_W-1:0]   out_q;
    logic                ov_q;

    logic [3:0]          op;
    logic [RS_W-1:0]     rd, rs;
    logic [DATA_W-1:0]   imm, a, b, res;
    logic [DATA_W:0]     sum;
    logic [ADDR_W-1:0]   tgt, pc_nx;
    logic                wr, c_nx, do_out;

    assign op   = ir[INSTR_W-1 -: 4];
    assign rd   = ir[INSTR_W-5 -: RS_W];
    assign rs   = ir[DATA_W+RS_W-1 -: RS_W];
    assign imm  = ir[DATA_W-1:0];
    assign a    = regs[rd];
    assign b    = regs[rs];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign tgt  = ADDR_W'(imm);

    always_comb begin
        res    = '0;
        wr     = 1'b0;
        c_nx   = c_q;
        pc_nx  = pc + ADDR_W'(1);
        do_out = 1'b0;
        case (op)
            4'h1: begin res = imm;                  wr = 1'b1; end
            4'h2: begin res = b;                    wr = 1'b1; end
            4'h3: begin res = sum[DATA_W-1:0];      wr = 1'b1; c_nx = sum[DATA_W]; end
            4'h4: begin res = a - b;                wr = 1'b1; c_nx = (a < b); end
            4'h5: begin res = a & b;                wr = 1'b1; c_nx = 1'b0; end
            4'h6: begin res = a | b;                wr = 1'b1; c_nx = 1'b0; end
            4'h7: begin res = a ^ b;                wr = 1'b1; c_nx = 1'b0; end
            4'h8: begin res = ~b;                   wr = 1'b1; c_nx = 1'b0; end
            4'h9: begin res = {b[DATA_W-2:0], 1'b0}; wr = 1'b1; c_nx = b[DATA_W-1]; end
            4'hA: pc_nx = tgt;
            4'hB: if (z_q) pc_nx = tgt;
            4'hC: if (c_q) pc_nx = tgt;
            4'hD: do_out = 1'b1;
            4'hE: pc_nx = pc;
            default: ;
        endcase
    end

    always_comb begin
        st_nx = st;
        case (st)
            S_FETCH:   if (run) st_nx = S_DECODE;
            S_DECODE:  st_nx = S_EXECUTE;
            S_EXECUTE: st_nx = (op == 4'hE) ? S_HALTED : S_FETCH;
            S_HALTED:  st_nx = S_HALTED;
            default:   st_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            out_q <= '0;
            ov_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            st   <= st_nx;
            ov_q <= 1'b0;
            if (st == S_DECODE) ir <= instr_data;
            // Operands were read combinationally above, so rd==rs sees the old value.
            if (st == S_EXECUTE) begin
                pc  <= pc_nx;
                c_q <= c_nx;
                if (wr) begin
                    regs[rd] <= res;
                    z_q      <= (res == '0);
                end
                if (do_out) begin
                    out_q <= b;
                    ov_q  <= 1'b1;
                end
            end
        end
    end

    assign instr_addr = pc;
    assign out_data   = out_q;
    assign out_valid  = ov_q;
    assign halted     = (st == S_HALTED);
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign state      = st;
    assign dbg_data   = regs[dbg_sel];

endmodule

// File: tb/tb_cpu_core_param.sv
// Self-checking bench for cpu_core_param: ALU vector table, hand-written
// corner sequences, random programs against an instruction-level model.
module tb_cpu_core_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (DATA_W=4, NREG=4, ADDR_W=4)
    logic        rst, run;
    logic [3:0]  instr_addr;
    logic [11:0] instr_data;
    logic [3:0]  out_data;
    logic        out_valid, halted, flag_z, flag_c;
    logic [1:0]  state;
    logic [1:0]  dbg_sel;
    logic [3:0]  dbg_data;
    logic [11:0] imem [16];

    cpu_core_param dut (
        .clk(clk), .rst(rst), .run(run), .instr_addr(instr_addr),
        .instr_data(instr_data), .out_data(out_data), .out_valid(out_valid),
        .halted(halted), .flag_z(flag_z), .flag_c(flag_c), .state(state),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );
    always @(posedge clk) instr_data <= imem[instr_addr];

    // Wide instance (DATA_W=8, NREG=8)
    logic        rst8, run8;
    logic [3:0]  ia8;
    logic [17:0] id8;
    logic [7:0]  od8, dd8;
    logic        ov8, h8, z8, c8;
    logic [1:0]  st8;
    logic [2:0]  ds8;
    logic [17:0] imem8 [16];

    cpu_core_param #(.DATA_W(8), .NREG(8), .ADDR_W(4)) dut8 (
        .clk(clk), .rst(rst8), .run(run8), .instr_addr(ia8),
        .instr_data(id8), .out_data(od8), .out_valid(ov8),
        .halted(h8), .flag_z(z8), .flag_c(c8), .state(st8),
        .dbg_sel(ds8), .dbg_data(dd8)
    );
    always @(posedge clk) id8 <= imem8[ia8];

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic [3:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output scoreboard: every out_valid pulse must match the next expected value.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got pulse with 0x%0h expected none at %0t", out_data, $time);
            end else begin
                chk("out_data_pulse", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [11:0] enc4(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [3:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [17:0] enc8(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] k, output logic [3:0] v);
        dbg_sel = k;
        #1;
        v = dbg_data;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) imem[i] = 12'h000;
    endtask

    // Instruction-level reference model
    int m_r [4];
    int m_pc, m_z, m_c, m_halt, m_ov, m_out;
    logic [11:0] prog [16];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_pc = 0; m_z = 0; m_c = 0; m_halt = 0; m_ov = 0; m_out = 0;
    endtask

    task automatic model_step();
        int op, rd, rs, imm, a, b, res, s, nxt, w;
        m_ov = 0;
        if (m_halt != 0) return;
        op  = int'(prog[m_pc][11:8]);
        rd  = int'(prog[m_pc][7:6]);
        rs  = int'(prog[m_pc][5:4]);
        imm = int'(prog[m_pc][3:0]);
        a = m_r[rd];
        b = m_r[rs];
        nxt = (m_pc + 1) % 16;
        w = 1;
        res = 0;
        case (op)
            1: res = imm;
            2: res = b;
            3: begin s = a + b; res = s % 16; m_c = (s >= 16) ? 1 : 0; end
            4: begin res = (a - b + 16) % 16; m_c = (a < b) ? 1 : 0; end
            5: begin res = a & b; m_c = 0; end
            6: begin res = a | b; m_c = 0; end
            7: begin res = a ^ b; m_c = 0; end
            8: begin res = 15 - b; m_c = 0; end
            9: begin res = (2 * b) % 16; m_c = (b >= 8) ? 1 : 0; end
            10: begin w = 0; nxt = imm; end
            11: begin w = 0; if (m_z != 0) nxt = imm; end
            12: begin w = 0; if (m_c != 0) nxt = imm; end
            13: begin w = 0; m_out = b; m_ov = 1; exp_q.push_back(4'(b)); end
            14: begin w = 0; m_halt = 1; nxt = m_pc; end
            default: w = 0;
        endcase
        if (w != 0) begin
            m_r[rd] = res;
            m_z = (res == 0) ? 1 : 0;
        end
        m_pc = nxt;
    endtask

    typedef struct {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [11:0] w;
        logic [3:0]  r0;
        logic        z;
        logic        c;
        string       name;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [3:0] v;
        rst = 1'b1; run = 1'b0; dbg_sel = 2'd0;
        rst8 = 1'b1; run8 = 1'b0; ds8 = 3'd0;
        clear_mem();
        for (int i = 0; i < 16; i++) imem8[i] = 18'h0;

        vt[0]  = '{4'hF, 4'h1, enc4(4'h3, 2'd0, 2'd1, 4'h0), 4'h0, 1'b1, 1'b1, "add_carry"};
        vt[1]  = '{4'h2, 4'h3, enc4(4'h3, 2'd0, 2'd1, 4'h0), 4'h5, 1'b0, 1'b0, "add_plain"};
        vt[2]  = '{4'h2, 4'h3, enc4(4'h4, 2'd0, 2'd1, 4'h0), 4'hF, 1'b0, 1'b1, "sub_borrow"};
        vt[3]  = '{4'h3, 4'h3, enc4(4'h4, 2'd0, 2'd1, 4'h0), 4'h0, 1'b1, 1'b0, "sub_zero"};
        vt[4]  = '{4'hC, 4'hA, enc4(4'h5, 2'd0, 2'd1, 4'h0), 4'h8, 1'b0, 1'b0, "and"};
        vt[5]  = '{4'h5, 4'hA, enc4(4'h6, 2'd0, 2'd1, 4'h0), 4'hF, 1'b0, 1'b0, "or"};
        vt[6]  = '{4'h5, 4'h5, enc4(4'h7, 2'd0, 2'd1, 4'h0), 4'h0, 1'b1, 1'b0, "xor_zero"};
        vt[7]  = '{4'h7, 4'h3, enc4(4'h8, 2'd0, 2'd1, 4'h0), 4'hC, 1'b0, 1'b0, "not"};
        vt[8]  = '{4'h7, 4'h9, enc4(4'h9, 2'd0, 2'd1, 4'h0), 4'h2, 1'b0, 1'b1, "shl_carry"};
        vt[9]  = '{4'h6, 4'h0, enc4(4'h2, 2'd0, 2'd1, 4'h0), 4'h0, 1'b1, 1'b0, "mov_zero"};
        vt[10] = '{4'h9, 4'h1, enc4(4'h3, 2'd0, 2'd0, 4'h0), 4'h2, 1'b0, 1'b1, "add_rd_eq_rs"};
        vt[11] = '{4'h7, 4'h4, enc4(4'h9, 2'd0, 2'd1, 4'h0), 4'h8, 1'b0, 1'b0, "shl_nocarry"};

        cycles(2);
        rst = 1'b0;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_pc", 32'(instr_addr), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_flags", 32'({flag_z, flag_c}), 32'd0);
        rd_reg(2'd3, v);
        chk("reset_r3", 32'(v), 32'd0);

        // ALU vector table: LDI r0,a ; LDI r1,b ; <op> ; HALT
        for (int i = 0; i < 12; i++) begin
            clear_mem();
            imem[0] = enc4(4'h1, 2'd0, 2'd0, vt[i].a);
            imem[1] = enc4(4'h1, 2'd1, 2'd0, vt[i].b);
            imem[2] = vt[i].w;
            imem[3] = enc4(4'hE, 2'd0, 2'd0, 4'h0);
            do_reset();
            run = 1'b1;
            cycles(9);
            rd_reg(2'd0, v);
            chk({vt[i].name, "_r0"}, 32'(v), 32'(vt[i].r0));
            chk({vt[i].name, "_z"}, 32'(flag_z), 32'(vt[i].z));
            chk({vt[i].name, "_c"}, 32'(flag_c), 32'(vt[i].c));
        end

        // Defaults program: single OUT of 8, then HALT holds pc at 4
        clear_mem();
        imem[0] = 12'h105; imem[1] = 12'h143; imem[2] = 12'h310;
        imem[3] = 12'hD00; imem[4] = 12'hE00;
        do_reset();
        pulses = 0;
        exp_q.push_back(4'h8);
        run = 1'b1;
        cycles(15);
        chk("dflt_halted", 32'(halted), 32'd1);
        chk("dflt_state", 32'(state), 32'd3);
        chk("dflt_addr", 32'(instr_addr), 32'd4);
        chk("dflt_out_data", 32'(out_data), 32'd8);
        chk("dflt_flags", 32'({flag_z, flag_c}), 32'd0);
        cycles(10);
        chk("dflt_addr_held", 32'(instr_addr), 32'd4);
        chk("dflt_halted_held", 32'(halted), 32'd1);
        chk("dflt_pulses", 32'(pulses), 32'd1);

        // Carry then taken JC
        clear_mem();
        imem[0] = 12'h10F; imem[1] = 12'h141; imem[2] = 12'h310; imem[3] = 12'hC07;
        do_reset();
        cycles(12);
        rd_reg(2'd0, v);
        chk("carry_r0", 32'(v), 32'd0);
        chk("carry_z", 32'(flag_z), 32'd1);
        chk("carry_c", 32'(flag_c), 32'd1);
        chk("carry_jc_addr", 32'(instr_addr), 32'd7);

        // Borrow then untaken JZ
        clear_mem();
        imem[0] = 12'h102; imem[1] = 12'h143; imem[2] = 12'h410; imem[3] = 12'hB00;
        do_reset();
        cycles(12);
        rd_reg(2'd0, v);
        chk("borrow_r0", 32'(v), 32'hF);
        chk("borrow_c", 32'(flag_c), 32'd1);
        chk("borrow_z", 32'(flag_z), 32'd0);
        chk("borrow_jz_addr", 32'(instr_addr), 32'd4);

        // Stall in FETCH, then pc wrap from 15 to 0
        clear_mem();
        imem[0] = 12'h105; imem[1] = 12'hA0F;
        do_reset();
        cycles(3);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            chk("stall_state", 32'(state), 32'd0);
            chk("stall_addr", 32'(instr_addr), 32'd1);
            chk("stall_out_valid", 32'(out_valid), 32'd0);
        end
        rd_reg(2'd0, v);
        chk("stall_r0", 32'(v), 32'd5);
        run = 1'b1;
        cycles(3);
        chk("jmp_addr15", 32'(instr_addr), 32'd15);
        cycles(3);
        chk("wrap_addr0", 32'(instr_addr), 32'd0);

        // Reset on the EXECUTE edge of ADD r0,r1
        clear_mem();
        imem[0] = 12'h105; imem[1] = 12'h143; imem[2] = 12'h310;
        do_reset();
        cycles(8);
        chk("midop_in_execute", 32'(state), 32'd2);
        rst = 1'b1;
        cycles(1);
        rd_reg(2'd0, v);
        chk("midop_r0", 32'(v), 32'd0);
        chk("midop_pc", 32'(instr_addr), 32'd0);
        chk("midop_state", 32'(state), 32'd0);
        chk("midop_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;

        // Wide configuration
        imem8[0] = enc8(4'h1, 3'd7, 3'd0, 8'hAA);
        imem8[1] = enc8(4'h8, 3'd6, 3'd7, 8'h00);
        imem8[2] = enc8(4'h9, 3'd5, 3'd7, 8'h00);
        imem8[3] = enc8(4'hE, 3'd0, 3'd0, 8'h00);
        rst8 = 1'b1;
        cycles(2);
        rst8 = 1'b0;
        run8 = 1'b1;
        cycles(9);
        ds8 = 3'd6; #1;
        chk("w8_r6", 32'(dd8), 32'h55);
        ds8 = 3'd5; #1;
        chk("w8_r5", 32'(dd8), 32'h54);
        chk("w8_c", 32'(c8), 32'd1);
        chk("w8_z", 32'(z8), 32'd0);
        cycles(3);
        chk("w8_halted", 32'(h8), 32'd1);

        // Random programs against the instruction-level model
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 16; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == 4'hE && $urandom_range(0, 3) != 0) op = 4'h0;
                prog[i] = enc4(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                               4'($urandom_range(0, 15)));
                imem[i] = prog[i];
            end
            model_reset();
            do_reset();
            run = 1'b1;
            for (int s = 0; s < 40; s++) begin
                logic [1:0] k;
                model_step();
                cycles(3);
                chk("rnd_addr", 32'(instr_addr), 32'(m_pc));
                chk("rnd_z", 32'(flag_z), 32'(m_z));
                chk("rnd_c", 32'(flag_c), 32'(m_c));
                chk("rnd_state", 32'(state), (m_halt != 0) ? 32'd3 : 32'd0);
                chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
                chk("rnd_out_data", 32'(out_data), 32'(m_out));
                k = 2'($urandom_range(0, 3));
                rd_reg(k, v);
                chk("rnd_reg", 32'(v), 32'(m_r[k]));
            end
        end

        cycles(2);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
Parametrised multi-cycle CPU core and next-generation replacement for the fixed 4-bit X/Y/Z datapath. It has a general register file of NREG registers, a DATA_W-bit ALU with carry/zero flags, and conditional branching. A FETCH/DECODE/EXECUTE state machine drives an external synchronous-read instruction memory. Output writes, halt, and a debug read port are exposed to the top level.

Parameters:
DATA_W, 4, datapath, register and immediate width (>=2)
NREG, 4, number of general registers (power of two, >=2); RS_W = clog2(NREG)
ADDR_W, 4, program counter / instruction address width; program depth 2^ADDR_W
INSTR_W, 4+2*RS_W+DATA_W, instruction width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  when low, core holds in FETCH (no fetch advance, no state change)
instr_addr  out  ADDR_W  instruction address = pc
instr_data  in  INSTR_W  instruction word; valid the cycle after instr_addr is presented
out_data  out  DATA_W  last value written by OUT
out_valid  out  1  one-cycle pulse when out_data is updated
halted  out  1  high while in HALTED state
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
state  out  2  FETCH=0, DECODE=1, EXECUTE=2, HALTED=3
dbg_sel  in  RS_W  register select for debug read
dbg_data  out  DATA_W  combinational read of reg[dbg_sel]

Behaviour:
- Reset (rst=1 at rising edge, wins over everything):
  - all registers 0, pc 0, flags 0, IR 0, out_data 0, out_valid 0, state FETCH.
  - Reset in any state abandons the instruction with no writeback.
- Instruction fields, MSB to LSB: op[3:0], rd[RS_W], rs[RS_W], imm[DATA_W].
- FSM:
  - FETCH: instr_addr=pc. If run=1, go to DECODE; else stay.
  - DECODE: latch instr_data into IR, go to EXECUTE.
  - EXECUTE: perform op, update regs/flags/pc, go to FETCH; HALT goes to HALTED.
  - HALTED: absorbing until reset.
- Latency: exactly 3 cycles per instruction with run=1.
- PC: pc <= pc+1 mod 2^ADDR_W in EXECUTE unless a jump is taken.
- Jump target = imm zero-extended or truncated to ADDR_W.
- Opcodes (R = reg file; ZC = Z and C updated, Z = result==0):
  - 0 NOP
  - 1 LDI R[rd]<=imm; Z updated, C kept
  - 2 MOV R[rd]<=R[rs]; Z updated, C kept
  - 3 ADD R[rd]<=R[rd]+R[rs]; C = carry out of DATA_W bits; ZC
  - 4 SUB R[rd]<=R[rd]-R[rs]; C=1 iff R[rd]<R[rs] unsigned (borrow); ZC
  - 5 AND, 6 OR, 7 XOR: R[rd]<=R[rd] op R[rs]; Z updated, C cleared
  - 8 NOT R[rd]<=~R[rs]; Z updated, C cleared
  - 9 SHL R[rd]<=R[rs]<<1; C = R[rs][DATA_W-1]; ZC
  - A JMP pc<=imm
  - B JZ pc<=imm if flag_z else pc+1
  - C JC pc<=imm if flag_c else pc+1
  - D OUT out_data<=R[rs]; out_valid=1 for exactly the following cycle
  - E HALT: pc not incremented
  - F reserved, behaves as NOP
- Arithmetic is unsigned, modulo 2^DATA_W. rd==rs is legal; the operand is read before the write.
- Flags are only written in EXECUTE. Jumps read the flags as they stood before that EXECUTE.
- out_valid is 0 in all cycles other than the one after an OUT EXECUTE. out_data holds its value between OUTs.
- dbg_data reflects register contents after the most recent edge. It has no side effects.

Test Plan:
- Defaults. Program 0x105 (LDI r0,5), 0x143 (LDI r1,3), 0x310 (ADD r0,r1), 0xD00 (OUT r0), 0xE00 (HALT) -> single out_valid pulse with out_data=8; flag_z=0, flag_c=0; halted=1 and instr_addr=4 held indefinitely.
- Carry: LDI r0,F; LDI r1,1; ADD r0,r1; JC 7 -> r0=0, flag_z=1, flag_c=1, next instr_addr=7.
- Borrow: LDI r0,2; LDI r1,3; SUB r0,r1; JZ 0 -> r0=F, flag_c=1, flag_z=0, branch not taken, next instr_addr=4.
- Wrap and stall: NOP at address 15 -> next fetch at 0. run=0 for 5 cycles in FETCH -> state=0, pc and regs unchanged, no out_valid.
- Reset mid-op: rst=1 on the EXECUTE edge of ADD r0,r1 (r0=5, r1=3) -> r0=0, pc=0, state=FETCH next cycle, no out_valid.
- DATA_W=8, NREG=8: LDI r7,0xAA; NOT r6,r7; SHL r5,r7 -> dbg r6=0x55, dbg r5=0x54, flag_c=1.
